// File: rtl/uart_fifo_tx.sv
// UART transmitter that pulls bytes from an upstream registered-read FIFO.
// Frame: start bit, 8 data bits LSB first, optional parity, 1 or 2 stop bits.
// Line output is registered; busy, fifo_rd_en and frame_done decode the state.
module uart_fifo_tx #(
    parameter int CLKS_PER_BIT = 868,
    parameter int PARITY_EN    = 0,
    parameter int PARITY_ODD   = 0,
    parameter int STOP_BITS    = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       tx_enable,
    input  logic       fifo_empty,
    input  logic [7:0] fifo_rd_data,
    output logic       fifo_rd_en,
    output logic       tx,
    output logic       busy,
    output logic       frame_done
);

    localparam int             CW        = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0]  BAUD_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [2:0]     STOP_LAST = 3'(STOP_BITS - 1);
    localparam logic           ODD_SEL   = (PARITY_ODD != 0);

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        LOAD,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;

    state_t          state, state_nxt;
    logic [CW-1:0]   baud_cnt, baud_cnt_nxt;
    logic [2:0]      bit_idx, bit_idx_nxt;
    logic [7:0]      shreg, shreg_nxt;
    logic            par_bit, par_bit_nxt;
    logic            tx_nxt;
    logic            armed;
    logic            baud_last;

    // Blocks frame-start decisions during the first cycle after reset release.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) armed <= 1'b0;
        else       armed <= 1'b1;
    end

    // State, counters, shift register and line register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            baud_cnt <= '0;
            bit_idx  <= '0;
            shreg    <= '0;
            par_bit  <= 1'b0;
            tx       <= 1'b1;
        end else begin
            state    <= state_nxt;
            baud_cnt <= baud_cnt_nxt;
            bit_idx  <= bit_idx_nxt;
            shreg    <= shreg_nxt;
            par_bit  <= par_bit_nxt;
            tx       <= tx_nxt;
        end
    end

    // Next-state and datapath; tx_nxt is the line level for the state being entered.
    // bit_idx counts data bits in DATA and is reused to count stop bits in STOP.
    always_comb begin
        state_nxt    = state;
        baud_cnt_nxt = baud_cnt;
        bit_idx_nxt  = bit_idx;
        shreg_nxt    = shreg;
        par_bit_nxt  = par_bit;
        tx_nxt       = tx;
        fifo_rd_en   = 1'b0;
        frame_done   = 1'b0;
        busy         = (state != IDLE);
        baud_last    = (baud_cnt == BAUD_LAST);

        case (state)
            IDLE: begin
                tx_nxt = 1'b1;
                if (armed && tx_enable && !fifo_empty) state_nxt = FETCH;
            end
            FETCH: begin
                fifo_rd_en = 1'b1;
                state_nxt  = LOAD;
            end
            LOAD: begin
                shreg_nxt    = fifo_rd_data;
                par_bit_nxt  = (^fifo_rd_data) ^ ODD_SEL;
                baud_cnt_nxt = '0;
                bit_idx_nxt  = '0;
                tx_nxt       = 1'b0;
                state_nxt    = START;
            end
            START: begin
                if (baud_last) begin
                    baud_cnt_nxt = '0;
                    tx_nxt       = shreg[0];
                    state_nxt    = DATA;
                end else begin
                    baud_cnt_nxt = baud_cnt + CW'(1);
                end
            end
            DATA: begin
                if (baud_last) begin
                    baud_cnt_nxt = '0;
                    bit_idx_nxt  = bit_idx + 3'd1;
                    if (bit_idx == 3'd7) begin
                        if (PARITY_EN != 0) begin
                            tx_nxt    = par_bit;
                            state_nxt = PARITY;
                        end else begin
                            tx_nxt    = 1'b1;
                            state_nxt = STOP;
                        end
                    end else begin
                        shreg_nxt = {1'b0, shreg[7:1]};
                        tx_nxt    = shreg[1];
                    end
                end else begin
                    baud_cnt_nxt = baud_cnt + CW'(1);
                end
            end
            PARITY: begin
                if (baud_last) begin
                    baud_cnt_nxt = '0;
                    tx_nxt       = 1'b1;
                    state_nxt    = STOP;
                end else begin
                    baud_cnt_nxt = baud_cnt + CW'(1);
                end
            end
            STOP: begin
                if (baud_last) begin
                    baud_cnt_nxt = '0;
                    if (bit_idx == STOP_LAST) begin
                        frame_done  = 1'b1;
                        bit_idx_nxt = '0;
                        if (tx_enable && !fifo_empty) state_nxt = FETCH;
                        else                          state_nxt = IDLE;
                    end else begin
                        bit_idx_nxt = bit_idx + 3'd1;
                    end
                end else begin
                    baud_cnt_nxt = baud_cnt + CW'(1);
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

endmodule

// File: tb/tb_uart_fifo_tx.sv
// Bench for uart_fifo_tx: three instances (plain, even parity, odd parity with
// two stop bits) share stimulus; each has its own FIFO model and frame monitor.
module tb_uart_fifo_tx;

    localparam int CPB = 4;
    localparam int PE [3] = '{0, 1, 1};
    localparam int PO [3] = '{0, 0, 1};
    localparam int SB [3] = '{1, 1, 2};

    logic       clk = 1'b0;
    logic       reset;
    logic       tx_enable;
    logic [2:0] fempty;
    logic [7:0] rd_data [3];
    logic [2:0] rd_en_w, tx_w, busy_w, fd_w;

    int errors = 0;
    int checks = 0;

    // FIFO model storage and log of bytes popped by each DUT
    logic [7:0] fmem [3][64];
    int         wptr [3];
    int         rptr [3];
    logic [7:0] plog [3][64];
    int         plw  [3];
    int         plr  [3];
    int         pops [3];

    // Monitor state
    logic       active [3];
    int         fcyc   [3];
    logic [7:0] cur    [3];
    int         frames [3];
    int         gap    [3];
    logic       b2b    [3];

    always #5 clk = ~clk;

    uart_fifo_tx #(.CLKS_PER_BIT(CPB), .PARITY_EN(PE[0]), .PARITY_ODD(PO[0]), .STOP_BITS(SB[0])) u0 (
        .clk(clk), .reset(reset), .tx_enable(tx_enable), .fifo_empty(fempty[0]),
        .fifo_rd_data(rd_data[0]), .fifo_rd_en(rd_en_w[0]), .tx(tx_w[0]),
        .busy(busy_w[0]), .frame_done(fd_w[0]));

    uart_fifo_tx #(.CLKS_PER_BIT(CPB), .PARITY_EN(PE[1]), .PARITY_ODD(PO[1]), .STOP_BITS(SB[1])) u1 (
        .clk(clk), .reset(reset), .tx_enable(tx_enable), .fifo_empty(fempty[1]),
        .fifo_rd_data(rd_data[1]), .fifo_rd_en(rd_en_w[1]), .tx(tx_w[1]),
        .busy(busy_w[1]), .frame_done(fd_w[1]));

    uart_fifo_tx #(.CLKS_PER_BIT(CPB), .PARITY_EN(PE[2]), .PARITY_ODD(PO[2]), .STOP_BITS(SB[2])) u2 (
        .clk(clk), .reset(reset), .tx_enable(tx_enable), .fifo_empty(fempty[2]),
        .fifo_rd_data(rd_data[2]), .fifo_rd_en(rd_en_w[2]), .tx(tx_w[2]),
        .busy(busy_w[2]), .frame_done(fd_w[2]));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: line level of frame slot 'slot' (one slot = one bit time)
    function automatic logic exp_bit(input int k, input logic [7:0] b, input int slot);
        if (slot == 0) return 1'b0;
        if (slot <= 8) return b[slot-1];
        if (PE[k] != 0 && slot == 9) return (^b) ^ (PO[k] != 0);
        return 1'b1;
    endfunction

    function automatic int flen(input int k);
        return (9 + PE[k] + SB[k]) * CPB;
    endfunction

    always_comb begin
        for (int k = 0; k < 3; k++) fempty[k] = (wptr[k] == rptr[k]);
    end

    // Registered-read FIFO model: data appears the cycle after the pop strobe.
    always @(posedge clk) begin
        for (int k = 0; k < 3; k++) begin
            if (rd_en_w[k]) begin
                chk("pop_nonempty", 32'(rptr[k] != wptr[k]), 32'd1);
                if (rptr[k] != wptr[k]) begin
                    rd_data[k]      <= fmem[k][rptr[k]];
                    plog[k][plw[k]] = fmem[k][rptr[k]];
                    plw[k]          = plw[k] + 1;
                    rptr[k]         <= rptr[k] + 1;
                    pops[k]         = pops[k] + 1;
                end
            end
        end
    end

    // Frame monitor: checks every line cycle, frame_done timing and inter-frame gaps.
    always @(negedge clk) begin
        for (int k = 0; k < 3; k++) begin
            if (reset) begin
                chk("rst_tx", 32'(tx_w[k]), 32'd1);
                chk("rst_busy", 32'(busy_w[k]), 32'd0);
                chk("rst_rd_en", 32'(rd_en_w[k]), 32'd0);
                chk("rst_frame_done", 32'(fd_w[k]), 32'd0);
                active[k] = 1'b0;
                plr[k]    = plw[k];
                b2b[k]    = 1'b0;
            end else begin
                if (!active[k] && tx_w[k] == 1'b0) begin
                    chk("start_has_pop", 32'(plr[k] < plw[k]), 32'd1);
                    if (b2b[k]) chk("b2b_gap", 32'(gap[k]), 32'd2);
                    cur[k]    = (plr[k] < plw[k]) ? plog[k][plr[k]] : 8'h00;
                    plr[k]    = plr[k] + 1;
                    active[k] = 1'b1;
                    fcyc[k]   = 0;
                    b2b[k]    = 1'b0;
                end
                if (active[k]) begin
                    chk("frame_tx", 32'(tx_w[k]), 32'(exp_bit(k, cur[k], fcyc[k] / CPB)));
                    chk("frame_done", 32'(fd_w[k]), 32'(fcyc[k] == flen(k) - 1));
                    chk("frame_busy", 32'(busy_w[k]), 32'd1);
                    fcyc[k] = fcyc[k] + 1;
                    if (fcyc[k] == flen(k)) begin
                        active[k] = 1'b0;
                        frames[k] = frames[k] + 1;
                        gap[k]    = 0;
                        b2b[k]    = 1'b1;
                    end
                end else begin
                    chk("idle_frame_done", 32'(fd_w[k]), 32'd0);
                    if (!busy_w[k]) b2b[k] = 1'b0;
                    gap[k] = gap[k] + 1;
                end
            end
        end
    end

    task automatic push_all(input logic [7:0] b);
        for (int k = 0; k < 3; k++) begin
            fmem[k][wptr[k]] = b;
            wptr[k]          = wptr[k] + 1;
        end
    endtask

    // Expect 'highs' idle-high samples, then the start bit on all instances.
    task automatic check_start(input int highs, input string tag);
        repeat (highs) begin
            @(negedge clk);
            chk(tag, 32'(tx_w), 32'b111);
        end
        @(negedge clk);
        chk(tag, 32'(tx_w), 32'b000);
    endtask

    task automatic wait_quiet(input int budget, input string tag);
        int n = 0;
        while (n < budget && busy_w != 3'b000) begin
            @(negedge clk);
            n++;
        end
        chk(tag, 32'(busy_w), 32'd0);
    endtask

    task automatic chk_counts(input int exp_frames, input int exp_pops, input string tag);
        for (int k = 0; k < 3; k++) begin
            chk({tag, "_frames"}, 32'(frames[k]), 32'(exp_frames));
            chk({tag, "_pops"}, 32'(pops[k]), 32'(exp_pops));
        end
    endtask

    initial begin
        for (int k = 0; k < 3; k++) begin
            wptr[k] = 0; rptr[k] = 0; plw[k] = 0; plr[k] = 0; pops[k] = 0;
            active[k] = 1'b0; fcyc[k] = 0; frames[k] = 0; gap[k] = 0; b2b[k] = 1'b0;
            rd_data[k] = 8'h00; cur[k] = 8'h00;
        end
        reset     = 1'b1;
        tx_enable = 1'b0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;

        // Empty FIFO with permission: nothing may happen
        tx_enable = 1'b1;
        repeat (100) begin
            @(negedge clk);
            chk("empty_tx", 32'(tx_w), 32'b111);
            chk("empty_rd_en", 32'(rd_en_w), 32'd0);
            chk("empty_busy", 32'(busy_w), 32'd0);
        end

        // Single byte 0xA5, including start latency
        @(posedge clk); #1 push_all(8'hA5);
        check_start(3, "a5_latency");
        wait_quiet(400, "a5_done");
        chk_counts(1, 1, "a5");

        // 0x07: parity 1 even / 0 odd
        @(posedge clk); #1 push_all(8'h07);
        check_start(3, "p07_latency");
        wait_quiet(400, "p07_done");
        chk_counts(2, 2, "p07");

        // Back-to-back frames
        @(posedge clk); #1 push_all(8'h11); push_all(8'h22); push_all(8'h33);
        check_start(3, "b2b_latency");
        wait_quiet(800, "b2b_done");
        chk_counts(5, 5, "b2b");

        // Random bytes, back-to-back
        @(posedge clk); #1;
        repeat (4) push_all(8'($urandom));
        check_start(3, "rnd_latency");
        wait_quiet(1000, "rnd_done");
        chk_counts(9, 9, "rnd");

        // tx_enable dropped mid-DATA with a second byte queued
        @(posedge clk); #1 push_all(8'($urandom)); push_all(8'($urandom));
        check_start(3, "drop_latency");
        repeat (8) @(negedge clk);
        tx_enable = 1'b0;
        wait_quiet(400, "drop_done");
        repeat (50) @(negedge clk);
        chk("drop_idle_busy", 32'(busy_w), 32'd0);
        for (int k = 0; k < 3; k++) chk("drop_left", 32'(wptr[k] - rptr[k]), 32'd1);
        chk_counts(10, 10, "drop");
        @(posedge clk); #1 tx_enable = 1'b1;
        check_start(3, "resume_latency");
        wait_quiet(400, "resume_done");
        chk_counts(11, 11, "resume");

        // Reset during DATA bit 3 with a second byte queued
        @(posedge clk); #1 push_all(8'($urandom)); push_all(8'($urandom));
        check_start(3, "rst_latency");
        repeat (18) @(posedge clk);
        #1 reset = 1'b1;
        #1;
        chk("rst_async_tx", 32'(tx_w), 32'b111);
        chk("rst_async_busy", 32'(busy_w), 32'd0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        check_start(4, "post_rst_latency");
        wait_quiet(400, "post_rst_done");
        chk_counts(12, 13, "post_rst");
        for (int k = 0; k < 3; k++) chk("post_rst_empty", 32'(fempty[k]), 32'd1);

        repeat (5) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/uart_fifo_tx.md
UART_FIFO_TX -- requirements
Module: uart_fifo_tx

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 868, meaning clk cycles per UART bit (100 MHz / 115200 baud); legal values are 2 or more.
REQ-002 SHALL have parameter PARITY_EN, default 0, meaning 1 inserts a parity bit after the data bits.
REQ-003 SHALL have parameter PARITY_ODD, default 0, meaning 1 selects odd parity and 0 selects even; ignored when PARITY_EN=0.
REQ-004 SHALL have parameter STOP_BITS, default 1, meaning number of stop bits; legal values 1 or 2.
REQ-005 SHALL have port clk  input  1  system clock; all state updates on its rising edge.
REQ-006 SHALL have port reset  input  1  reset, asynchronous, active-high.
REQ-007 SHALL have port tx_enable  input  1  permission to start new frames; sampled only at frame-start decisions.
REQ-008 SHALL have port fifo_empty  input  1  empty flag of the upstream 8-bit FIFO.
REQ-009 SHALL have port fifo_rd_data  input  8  FIFO read data; registered in the FIFO, valid the cycle after fifo_rd_en.
REQ-010 SHALL have port fifo_rd_en  output  1  FIFO pop strobe.
REQ-011 SHALL have port tx  output  1  serial line; idle high; registered.
REQ-012 SHALL have port busy  output  1  high whenever state is not IDLE.
REQ-013 SHALL have port frame_done  output  1  one-cycle pulse at the end of the last stop bit.

Function
REQ-014 SHALL implement the states IDLE, FETCH, LOAD, START, DATA, PARITY and STOP.
REQ-015 SHALL go from IDLE to FETCH when tx_enable=1 and fifo_empty=0 are sampled; otherwise it SHALL stay in IDLE.
REQ-016 SHALL assert fifo_rd_en only while in FETCH, for exactly one cycle per frame, and never while fifo_empty=1.
REQ-017 SHALL, in LOAD, capture fifo_rd_data into an 8-bit shift register, compute the parity bit, and enter START.
REQ-018 SHALL drive tx low for START, starting on the clock edge that leaves LOAD, so that tx falls 3 edges after the IDLE sample.
REQ-019 SHALL hold each of START, each DATA bit, and PARITY for exactly CLKS_PER_BIT cycles, using a baud counter that runs from 0 to CLKS_PER_BIT-1 and wraps.
REQ-020 SHALL send the data bits LSB first, 8 bits, counted by a 3-bit bit index that wraps from 7 to 0 as DATA exits.
REQ-021 SHALL go from DATA to PARITY when PARITY_EN=1, otherwise from DATA to STOP.
REQ-022 SHALL send a parity bit equal to XOR of the 8 data bits, inverted when PARITY_ODD=1.
REQ-023 SHALL drive tx high in STOP for STOP_BITS*CLKS_PER_BIT cycles.
REQ-024 SHALL pulse frame_done in the final cycle of STOP.
REQ-025 SHALL, at the end of STOP, go directly to FETCH when tx_enable=1 and fifo_empty=0, otherwise to IDLE.
REQ-026 SHALL keep tx high for exactly 2 cycles (FETCH and LOAD) between back-to-back frames.
REQ-027 SHALL complete a frame in progress when tx_enable is deasserted mid-frame, and SHALL then not start another frame.
REQ-028 SHALL ignore changes on fifo_empty and fifo_rd_data outside IDLE, the STOP exit, and LOAD.
REQ-029 SHALL make a frame last (1 + 8 + PARITY_EN + STOP_BITS) * CLKS_PER_BIT cycles from tx falling to frame_done inclusive.

Reset
REQ-030 SHALL, while reset=1, immediately force state=IDLE, tx=1, busy=0, fifo_rd_en=0, frame_done=0, and clear the counters and the shift register.
REQ-031 SHALL abort a frame when reset is asserted mid-frame, with no further FIFO pop and tx high; the aborted byte is lost.
REQ-032 SHALL take no action in the first cycle after reset release and SHALL then evaluate the IDLE start condition normally.

Verification
REQ-033 SHALL pass this scenario (CLKS_PER_BIT=4, no parity, 1 stop): FIFO holds 0xA5, tx_enable=1 -> one fifo_rd_en pulse; tx = 0, then 1,0,1,0,0,1,0,1, then 1, each held 4 cycles; frame_done at cycle 40 after tx falls.
REQ-034 SHALL pass this scenario: PARITY_EN=1, PARITY_ODD=0, byte 0x07 -> parity bit 1; with PARITY_ODD=1 -> parity bit 0; frame is 44 cycles.
REQ-035 SHALL pass this scenario: FIFO holds 0x11, 0x22, 0x33 -> three frames with exactly 2 high cycles between them, 3 pops total, busy stays high, IDLE reached after the third frame.
REQ-036 SHALL pass this scenario: tx_enable dropped during DATA of the first of 2 queued bytes -> first frame completes, no second pop, busy falls after frame_done.
REQ-037 SHALL pass this scenario: reset pulsed during DATA bit 3 -> tx=1 and busy=0 in the same cycle; after release with FIFO non-empty, the next byte is sent as a complete frame.
REQ-038 SHALL pass this scenario: fifo_empty=1 with tx_enable=1 for 100 cycles -> fifo_rd_en never asserted, tx=1 throughout; STOP_BITS=2 -> stop high for 8 cycles.
